// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern engine (binary, scan, breathe, off).
// Define LED_ACTIVE_LOW_EN to invert the leds output for active-low boards.
module led_pattern_gen #(
  parameter int NUM_LEDS   = 8,
  parameter int PRESCALE_W = 18,
  parameter int PWM_W      = 4
) (
  input  logic                hwclk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] leds,
  output logic                step
);

  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  localparam logic [1:0] M_BIN  = 2'b00;
  localparam logic [1:0] M_SCAN = 2'b01;
  localparam logic [1:0] M_BRTH = 2'b10;
  localparam logic [1:0] M_OFF  = 2'b11;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  logic [PRESCALE_W-1:0] presc, presc_nxt;
  logic [1:0]            mode_q, mode_nxt;
  logic [NUM_LEDS-1:0]   count, count_nxt;
  logic [POS_W-1:0]      pos, pos_nxt;
  dir_t                  dir, dir_nxt;
  logic [PWM_W-1:0]      duty, duty_nxt;
  dir_t                  ramp, ramp_nxt;
  logic [PWM_W-1:0]      pwm_cnt, pwm_nxt;
  logic [NUM_LEDS-1:0]   leds_q, leds_d;
  logic                  step_q;
  logic                  tick, load, adv;

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      mode_q  <= M_OFF;
      count   <= '0;
      pos     <= '0;
      dir     <= UP;
      duty    <= '0;
      ramp    <= UP;
      pwm_cnt <= '0;
      leds_q  <= '0;
      step_q  <= 1'b0;
    end else begin
      presc   <= presc_nxt;
      mode_q  <= mode_nxt;
      count   <= count_nxt;
      pos     <= pos_nxt;
      dir     <= dir_nxt;
      duty    <= duty_nxt;
      ramp    <= ramp_nxt;
      pwm_cnt <= pwm_nxt;
      leds_q  <= leds_d;
      step_q  <= adv;
    end
  end

  always_comb begin
    tick      = (&presc) && !pause;
    load      = tick && (mode != mode_q);
    adv       = tick && (mode == mode_q);
    presc_nxt = pause ? presc : presc + 1'b1;
    pwm_nxt   = pause ? pwm_cnt : pwm_cnt + 1'b1;
    mode_nxt  = mode_q;
    count_nxt = count;
    pos_nxt   = pos;
    dir_nxt   = dir;
    duty_nxt  = duty;
    ramp_nxt  = ramp;

    if (load) begin
      mode_nxt  = mode;
      count_nxt = '0;
      pos_nxt   = '0;
      dir_nxt   = UP;
      duty_nxt  = '0;
      ramp_nxt  = UP;
    end else if (adv) begin
      unique case (mode_q)
        M_BIN: count_nxt = count + 1'b1;
        M_SCAN: begin
          // endpoints flip direction on arrival so they dwell one step only
          if (NUM_LEDS > 1) begin
            unique case (dir)
              UP: begin
                pos_nxt = pos + 1'b1;
                if (pos_nxt == POS_LAST) dir_nxt = DOWN;
              end
              DOWN: begin
                pos_nxt = pos - 1'b1;
                if (pos_nxt == '0) dir_nxt = UP;
              end
            endcase
          end
        end
        M_BRTH: begin
          unique case (ramp)
            UP: begin
              duty_nxt = duty + 1'b1;
              if (duty_nxt == DUTY_MAX) ramp_nxt = DOWN;
            end
            DOWN: begin
              duty_nxt = duty - 1'b1;
              if (duty_nxt == '0) ramp_nxt = UP;
            end
          endcase
        end
        default: ;
      endcase
    end

    // leds register is fed from next-state so it changes with step
    leds_d = '0;
    unique case (mode_nxt)
      M_BIN:  leds_d = count_nxt;
      M_SCAN: leds_d[pos_nxt] = 1'b1;
      M_BRTH: leds_d = {NUM_LEDS{pwm_nxt < duty_nxt}};
      default: leds_d = '0;
    endcase
  end

`ifdef LED_ACTIVE_LOW_EN
  assign leds = ~leds_q;
`else
  assign leds = leds_q;
`endif
  assign step = step_q;

endmodule
